uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit path (byte transmitter FSM + shift register) between NUM_REQ byte sources, e.g. the CPU store port, a debug/print unit and a boot-loader echo.
- Each source offers bytes over a valid/ready handshake.
- The arbiter picks one source round-robin, latches its byte, pulses a start to the transmitter and holds the data stable until the transmitter reports frame done.
- Sits between the bus-side requesters and the UART transmitter inside the UART subsystem.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..8
DATA_W, 8, byte width carried to the transmitter
IDX_W, $clog2(NUM_REQ), derived width of the grant index; not overridden

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  NUM_REQ  per-requester byte valid
req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high
req_data_i  input  NUM_REQ*DATA_W  flattened bytes; requester k at [k*DATA_W +: DATA_W]
req_last_i  input  NUM_REQ  end-of-message flag; used only with lock feature
tx_start_o  output  1  one-cycle start pulse to the transmitter
tx_data_o  output  DATA_W  byte to transmit; stable from start until done
tx_done_i  input  1  one-cycle pulse from the transmitter at end of stop bit
busy_o  output  1  high in any state other than IDLE
grant_o  output  NUM_REQ  one-hot owner of the transmit path; zero in IDLE

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset state:
  - FSM in IDLE.
  - tx_data_o, grant_o, tx_start_o, busy_o, req_ready_o all 0.
  - Round-robin pointer set to 0, so requester 0 has top priority first.
- FSM states: IDLE, LOAD, BUSY.
- IDLE:
  - Winner = first k with req_valid_i[k]=1, searching from pointer upward with wrap-around modulo NUM_REQ.
  - req_ready_o[winner] is asserted combinationally in the same cycle, so valid&ready completes the transfer.
  - On that edge: data_q <= req_data_i[winner], grant_q <= winner, go to LOAD.
  - No valid requester: stay in IDLE with all outputs 0.
- LOAD: tx_start_o=1 for exactly this one cycle; go to BUSY.
- BUSY:
  - Wait for tx_done_i.
  - On tx_done_i: go to IDLE and set pointer <= (grant_q+1) mod NUM_REQ.
- tx_data_o = data_q and grant_o = onehot(grant_q) throughout LOAD and BUSY.
- Latency:
  - Accept to tx_start_o: 1 cycle.
  - tx_done_i to next possible accept: 1 cycle (IDLE is re-entered on the next edge).
- Boundary conditions:
  - tx_done_i in IDLE or LOAD is ignored.
  - req_ready_o is 0 outside IDLE; valid held by a requester while not granted must stay pending (requesters must not drop data).
  - All requesters valid continuously: grants rotate 0,1,...,NUM_REQ-1,0, so no requester waits more than NUM_REQ frames.
  - Pointer at NUM_REQ-1: wraps to 0.
  - Reset asserted mid-frame: immediate return to IDLE and the in-flight byte is dropped; the transmitter has its own reset.
  - req_data_i of non-winners is don't-care.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN (message lock).
- Defined:
  - Accepting a byte with req_last_i[winner]=0 sets lock_q.
  - While lock_q is set, IDLE considers only grant_q, so other requesters' valid is masked and multi-byte messages are not interleaved.
  - Accepting a byte with last=1 clears lock_q after its frame.
  - The pointer advances only when the lock is released.
  - Reset clears lock_q.
- Undefined: req_last_i is ignored, lock_q does not exist, and arbitration is round-robin per byte.

Decomposition:
- Package uart_arb_pkg:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_LOAD, ARB_BUSY}.
  - Constants UART_DATA_W=8 and UART_MAX_REQ=8.
- Sub-module uart_rr_pick: combinational rotate-mask priority picker (inputs req vector and pointer; outputs winner index and found flag). It is reusable for a future RX-side scheduler.

Test Plan:
- Reset, then req_valid_i=2'b01 with data 8'h41 → req_ready_o=2'b01 same cycle; tx_start_o pulses next cycle; tx_data_o=8'h41 and grant_o=2'b01 until tx_done_i; busy_o low one cycle after done.
- Both valid continuously (req0=8'h10, req1=8'h20), done returned 20 cycles after each start → tx_data_o sequence 10,20,10,20; req_ready_o never 2'b11.
- tx_done_i pulsed in IDLE and again in LOAD → ignored; FSM remains in BUSY until a done in BUSY.
- rst_ni dropped for 1 cycle mid-BUSY → all outputs 0 asynchronously; after release req1 valid alone gets an immediate grant with pointer 0.
- NUM_REQ=3, only req2 valid repeatedly → granted every frame; pointer wraps to 0 after each grant.
- With UART_TX_ARB_LOCK_EN, req0 sends 3 bytes with last=0,0,1 while req1 is valid → req0 bytes go out consecutively, then req1. Without the macro the bytes interleave 0,1,0,1,0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART transmit-path arbiter and its
// round-robin picker.
//
// Contents:
//   arb_state_e   - arbiter FSM state encoding (IDLE, LOAD, BUSY)
//   UART_DATA_W   - default byte width carried to the transmitter
//   UART_MAX_REQ  - largest supported number of requesters
//   rr_next()     - round-robin successor of an index, wrapping at n
// ---------------------------------------------------------------------------
package uart_arb_pkg;

   localparam int UART_DATA_W  = 8;
   localparam int UART_MAX_REQ = 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_LOAD = 2'd1,
      ARB_BUSY = 2'd2
   } arb_state_e;

   // Next index after idx in a ring of n entries.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      if (idx + 1 >= n) begin
         return 0;
      end
      return idx + 1;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin priority picker. Returns the first asserted
// request found when searching upward from ptr_i, wrapping past the top
// index back to 0. Kept free of any UART specifics so that it can also
// serve an RX-side scheduler.
//
// Ports:
//   req_i   [NUM_REQ-1:0]  request vector
//   ptr_i   [IDX_W-1:0]    index with highest priority this cycle
//   idx_o   [IDX_W-1:0]    index of the winning request (0 if none)
//   found_o                at least one request asserted
// ---------------------------------------------------------------------------
module uart_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   idx_o,
   output logic               found_o
);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] req_upper;
   logic [IDX_W-1:0]   idx_hi;
   logic [IDX_W-1:0]   idx_lo;
   logic               found_hi;
   logic               found_lo;

   // Rotate-by-mask: requests at or above the pointer are searched first
   // (lowest wins); if none of those are set, the search wraps and the
   // lowest request overall wins.
   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upper_mask[i] = (IDX_W'(i) >= ptr_i);
      end
      req_upper = req_i & upper_mask;
   end

   // Lowest-set-bit search over both vectors; iterating downward lets the
   // last assignment (the lowest index) win.
   always_comb begin
      idx_hi   = '0;
      idx_lo   = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_upper[i]) begin
            idx_hi   = IDX_W'(i);
            found_hi = 1'b1;
         end
         if (req_i[i]) begin
            idx_lo   = IDX_W'(i);
            found_lo = 1'b1;
         end
      end
   end

   assign idx_o   = found_hi ? idx_hi : idx_lo;
   assign found_o = found_lo;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte sources. In IDLE the
// arbiter accepts one byte round-robin over a valid/ready handshake,
// pulses tx_start_o for one cycle (LOAD), then holds the byte and grant
// stable until the transmitter reports tx_done_i (BUSY).
//
// Optional feature (macro UART_TX_ARB_LOCK_EN): message lock. A byte
// accepted with req_last_i=0 locks the path to its requester so that a
// multi-byte message is never interleaved; the round-robin pointer only
// advances once the message's last byte has been sent. Without the macro
// req_last_i is ignored and arbitration is per byte.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester byte valid
//   req_ready_o  per-requester accept (at most one bit high, IDLE only)
//   req_data_i   flattened bytes, requester k at [k*DATA_W +: DATA_W]
//   req_last_i   end-of-message flag (lock feature only)
//   tx_start_o   one-cycle start pulse to the transmitter
//   tx_data_o    byte to transmit, stable from start until done
//   tx_done_i    one-cycle pulse from the transmitter at end of stop bit
//   busy_o       high whenever not IDLE
//   grant_o      one-hot owner of the transmit path, zero in IDLE
// ---------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int  NUM_REQ = 2,
   parameter int  DATA_W  = UART_DATA_W,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic                      tx_start_o,
   output logic [DATA_W-1:0]         tx_data_o,
   input  logic                      tx_done_i,
   output logic                      busy_o,
   output logic [NUM_REQ-1:0]        grant_o
);

   localparam logic [1:0] ST_IDLE = 2'(ARB_IDLE);
   localparam logic [1:0] ST_LOAD = 2'(ARB_LOAD);
   localparam logic [1:0] ST_BUSY = 2'(ARB_BUSY);

   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [DATA_W-1:0]  data_q, data_d;

   logic [NUM_REQ-1:0] cand_req;
   logic [NUM_REQ-1:0] grant_oh;
   logic [NUM_REQ-1:0] win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic               accept;

`ifdef UART_TX_ARB_LOCK_EN
   logic               lock_q, lock_d;
`else
   logic               unused_last;
   assign unused_last = ^req_last_i;
`endif

   assign grant_oh = ONE_HOT_0 << grant_q;
   assign win_oh   = ONE_HOT_0 << win_idx;

   // While a message is locked only its owner (still held in grant_q)
   // may compete; everyone else's valid stays pending.
`ifdef UART_TX_ARB_LOCK_EN
   assign cand_req = lock_q ? (req_valid_i & grant_oh) : req_valid_i;
`else
   assign cand_req = req_valid_i;
`endif

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i   (cand_req),
      .ptr_i   (ptr_q),
      .idx_o   (win_idx),
      .found_o (win_found)
   );

   // Handshake completes in the same IDLE cycle the winner is chosen.
   assign accept      = (state_q == ST_IDLE) && win_found;
   assign req_ready_o = accept ? win_oh : '0;

   // Next-state logic: latch the winner's byte on accept, issue the start
   // in LOAD, and advance the pointer past the owner when the frame ends.
   // A tx_done_i outside BUSY belongs to no frame of ours and is ignored.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
`ifdef UART_TX_ARB_LOCK_EN
      lock_d  = lock_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               data_d  = req_data_i[int'(win_idx)*DATA_W +: DATA_W];
               grant_d = win_idx;
               state_d = ST_LOAD;
`ifdef UART_TX_ARB_LOCK_EN
               lock_d  = ~req_last_i[win_idx];
`endif
            end
         end
         ST_LOAD: begin
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (tx_done_i) begin
               state_d = ST_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
               if (!lock_q) begin
                  ptr_d = IDX_W'(rr_next(32'(grant_q), NUM_REQ));
               end
`else
               ptr_d = IDX_W'(rr_next(32'(grant_q), NUM_REQ));
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight byte and restores
   // requester 0 as top priority.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
`ifdef UART_TX_ARB_LOCK_EN
         lock_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
`ifdef UART_TX_ARB_LOCK_EN
         lock_q  <= lock_d;
`endif
      end
   end

   // grant_q and data_q keep their last values through IDLE (the lock
   // needs the owner), so the outputs are gated to read zero there.
   assign busy_o     = (state_q != ST_IDLE);
   assign tx_start_o = (state_q == ST_LOAD);
   assign tx_data_o  = busy_o ? data_q : '0;
   assign grant_o    = busy_o ? grant_oh : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. A two-requester instance is
// driven from per-requester byte queues and compared against a
// transaction-level reference (round-robin order, optional message lock);
// a three-requester instance covers pointer wrap-around.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N = 2;
   localparam int W = 8;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic [N-1:0]   req_valid_i;
   logic [N-1:0]   req_ready_o;
   logic [N*W-1:0] req_data_i;
   logic [N-1:0]   req_last_i;
   logic           tx_start_o;
   logic [W-1:0]   tx_data_o;
   logic           tx_done_i;
   logic           busy_o;
   logic [N-1:0]   grant_o;

   logic [2:0]     v3;
   logic [2:0]     rdy3;
   logic [23:0]    data3;
   logic [2:0]     last3;
   logic           start3;
   logic [7:0]     txd3;
   logic           done3;
   logic           busy3;
   logic [2:0]     grant3;

   always #5 clk_i = ~clk_i;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .tx_start_o  (tx_start_o),
      .tx_data_o   (tx_data_o),
      .tx_done_i   (tx_done_i),
      .busy_o      (busy_o),
      .grant_o     (grant_o)
   );

   uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (v3),
      .req_ready_o (rdy3),
      .req_data_i  (data3),
      .req_last_i  (last3),
      .tx_start_o  (start3),
      .tx_data_o   (txd3),
      .tx_done_i   (done3),
      .busy_o      (busy3),
      .grant_o     (grant3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: pending bytes per requester and arbitration order.
   logic [7:0] q_data [N][$];
   bit         q_last [N][$];
   int         ptr_m;
   bit         lock_m;
   int         owner_m;
   logic [7:0]   dseq [$];
   logic [N-1:0] gseq [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic reset_model();
      ptr_m   = 0;
      lock_m  = 1'b0;
      owner_m = 0;
      for (int k = 0; k < N; k++) begin
         q_data[k].delete();
         q_last[k].delete();
      end
   endtask

   task automatic push_byte(input int k, input logic [7:0] d, input bit last);
      q_data[k].push_back(d);
      q_last[k].push_back(last);
   endtask

   task automatic push_msg(input int k, input int len);
      for (int i = 0; i < len; i++) begin
         push_byte(k, 8'($urandom), (i == len - 1));
      end
   endtask

   // Requesters present the head of their queue; idle lanes carry junk.
   task automatic drive_inputs();
      for (int k = 0; k < N; k++) begin
         if (q_data[k].size() > 0) begin
            req_valid_i[k]       = 1'b1;
            req_data_i[k*W +: W] = q_data[k][0];
            req_last_i[k]        = q_last[k][0];
         end else begin
            req_valid_i[k]       = 1'b0;
            req_data_i[k*W +: W] = 8'($urandom);
            req_last_i[k]        = 1'($urandom);
         end
      end
   endtask

   // Who should be served next: the lock owner while a message is open,
   // otherwise the first pending requester at or after the pointer.
   function automatic int exp_winner();
`ifdef UART_TX_ARB_LOCK_EN
      if (lock_m) begin
         return (q_data[owner_m].size() > 0) ? owner_m : -1;
      end
`endif
      for (int i = 0; i < N; i++) begin
         if (q_data[(ptr_m + i) % N].size() > 0) begin
            return (ptr_m + i) % N;
         end
      end
      return -1;
   endfunction

   // One complete arbitration + frame, done pulsed done_delay cycles
   // into BUSY; optionally a stray done is offered during LOAD.
   task automatic run_frame(input int done_delay, input bit done_in_load);
      int         w;
      logic [7:0] b;
      bit         l;
      drive_inputs();
      #1;
      w = exp_winner();
      if (w < 0) begin
         check("ready_none", 32'(req_ready_o), 32'd0);
         check("busy_none", 32'(busy_o), 32'd0);
         tick();
         return;
      end
      check("ready_idle", 32'(req_ready_o), 32'(1) << w);
      b = q_data[w].pop_front();
      l = q_last[w].pop_front();
`ifdef UART_TX_ARB_LOCK_EN
      lock_m  = !l;
      owner_m = w;
`endif
      tick();
      drive_inputs();
      tx_done_i = done_in_load;
      #1;
      check("start_load", 32'(tx_start_o), 32'd1);
      check("data_load", 32'(tx_data_o), 32'(b));
      check("grant_load", 32'(grant_o), 32'(1) << w);
      check("busy_load", 32'(busy_o), 32'd1);
      check("ready_load", 32'(req_ready_o), 32'd0);
      dseq.push_back(tx_data_o);
      gseq.push_back(grant_o);
      tick();
      tx_done_i = 1'b0;
      #1;
      check("start_busy", 32'(tx_start_o), 32'd0);
      check("data_busy", 32'(tx_data_o), 32'(b));
      check("busy_busy", 32'(busy_o), 32'd1);
      check("ready_busy", 32'(req_ready_o), 32'd0);
      for (int i = 0; i < done_delay; i++) begin
         tick();
         check("data_hold", 32'(tx_data_o), 32'(b));
         check("grant_hold", 32'(grant_o), 32'(1) << w);
      end
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
      #1;
      check("busy_after_done", 32'(busy_o), 32'd0);
      check("grant_after_done", 32'(grant_o), 32'd0);
      check("data_after_done", 32'(tx_data_o), 32'd0);
      check("start_after_done", 32'(tx_start_o), 32'd0);
      if (!lock_m) begin
         ptr_m = (w + 1) % N;
      end
   endtask

   initial begin
      logic [7:0]   exp_d [4];
      logic [N-1:0] exp_g [5];

      rst_ni      = 1'b0;
      tx_done_i   = 1'b0;
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
      v3          = '0;
      data3       = '0;
      last3       = '0;
      done3       = 1'b0;
      reset_model();

      // Reset state.
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_grant", 32'(grant_o), 32'd0);
      check("rst_start", 32'(tx_start_o), 32'd0);
      check("rst_data", 32'(tx_data_o), 32'd0);
      check("rst_ready", 32'(req_ready_o), 32'd0);
      rst_ni = 1'b1;
      tick();

      // Single byte from requester 0.
      push_byte(0, 8'h41, 1'b1);
      run_frame(5, 1'b0);
      check("t1_data", 32'(dseq[$]), 32'h41);
      check("t1_grant", 32'(gseq[$]), 32'h1);

      // Stray done in IDLE, then again in LOAD.
      drive_inputs();
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
      #1;
      check("idle_done_ignored", 32'(busy_o), 32'd0);
      push_byte(1, 8'h77, 1'b1);
      run_frame(3, 1'b1);

      // Both requesters continuously valid, done 20 cycles after start.
      dseq.delete();
      push_byte(0, 8'h10, 1'b1);
      push_byte(0, 8'h10, 1'b1);
      push_byte(1, 8'h20, 1'b1);
      push_byte(1, 8'h20, 1'b1);
      repeat (4) run_frame(18, 1'b0);
      exp_d = '{8'h10, 8'h20, 8'h10, 8'h20};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_seq%0d", i), 32'(dseq[i]), 32'(exp_d[i]));
      end

      // Message lock: requester 0 sends a 3-byte message against requester 1.
      gseq.delete();
      push_byte(0, 8'h01, 1'b0);
      push_byte(0, 8'h02, 1'b0);
      push_byte(0, 8'h03, 1'b1);
      push_byte(1, 8'hA1, 1'b1);
      push_byte(1, 8'hA2, 1'b1);
      repeat (5) run_frame(2, 1'b0);
`ifdef UART_TX_ARB_LOCK_EN
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
`else
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
      for (int i = 0; i < 5; i++) begin
         check($sformatf("msg_seq%0d", i), 32'(gseq[i]), 32'(exp_g[i]));
      end

      // Reset asserted mid-BUSY.
      reset_model();
      push_byte(0, 8'h55, 1'b1);
      drive_inputs();
      tick();
      tick();
      @(negedge clk_i);
      rst_ni      = 1'b0;
      req_valid_i = '0;
      #1;
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_grant", 32'(grant_o), 32'd0);
      check("arst_data", 32'(tx_data_o), 32'd0);
      check("arst_start", 32'(tx_start_o), 32'd0);
      check("arst_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      reset_model();
      push_byte(1, 8'h66, 1'b1);
      run_frame(2, 1'b0);
      check("arst_next_data", 32'(dseq[$]), 32'h66);

      // Randomized traffic: whole messages of 1..3 bytes.
      for (int f = 0; f < 40; f++) begin
         if ((q_data[0].size() + q_data[1].size() == 0) || ($urandom_range(0, 1) == 1)) begin
            push_msg(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 3)));
         end
         run_frame(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end

      // Three requesters, only requester 2 active: pointer wraps to 0.
      for (int i = 0; i < 3; i++) begin
         v3           = 3'b100;
         data3[23:16] = 8'(8'hA0 + i);
         #1;
         check("n3_ready", 32'(rdy3), 32'h4);
         tick();
         v3 = 3'b000;
         #1;
         check("n3_start", 32'(start3), 32'd1);
         check("n3_grant", 32'(grant3), 32'h4);
         check("n3_data", 32'(txd3), 32'(8'(8'hA0 + i)));
         tick();
         done3 = 1'b1;
         tick();
         done3 = 1'b0;
         #1;
         check("n3_idle", 32'(busy3), 32'd0);
      end
      v3 = 3'b101;
      #1;
      check("n3_wrap", 32'(rdy3), 32'h1);
      v3 = 3'b000;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
